operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural registers; AW = $clog2(REG_NUM).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, operand width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports in_valid  input  1 and in_ready  output  1  issue handshake.
REQ-006 SHALL have ports in_rs1, in_rs2, in_rd  input  AW each; in_rd_wen  input  1  source/destination registers of the issuing instruction.
REQ-007 SHALL have port rf_raddr  output  [2][AW]  register-file read addresses (index 0 = rs1, 1 = rs2).
REQ-008 SHALL have port rf_rdata  input  [2][DW]  combinational register-file read data.
REQ-009 SHALL have ports wb_valid  input  1, wb_addr  input  AW, wb_data  input  DW  writeback, same values presented to the register-file write port.
REQ-010 SHALL have port flush  input  1  discard all in-flight state.
REQ-011 SHALL have ports out_valid  output  1 and out_ready  input  1  execute-side handshake.
REQ-012 SHALL have ports out_rs1_data, out_rs2_data  output  DW; out_rd  output  AW; out_rd_wen  output  1.
REQ-013 SHALL have port busy_cnt  output  $clog2(REG_NUM)+1  number of set scoreboard bits.

Function
REQ-014 rf_raddr SHALL equal {in_rs1, in_rs2} combinationally every cycle.
REQ-015 Scoreboard SHALL hold one busy bit per register; busy[0] SHALL always read 0.
REQ-016 Source hazard: rsN!=0 and busy[rsN] and not (wb_valid and wb_addr==rsN).
REQ-017 WAW hazard: in_rd_wen and in_rd!=0 and busy[in_rd] and not (wb_valid and wb_addr==in_rd).
REQ-018 in_ready SHALL be 1 iff no flush, no source hazard, no WAW hazard, and (out_valid==0 or out_ready==1).
REQ-019 On accept (in_valid and in_ready), operand N SHALL capture wb_data if wb_valid and wb_addr==rsN and rsN!=0, else rf_rdata[N]; rsN==0 SHALL yield 0.
REQ-020 Latency SHALL be exactly 1 cycle: captured operands, rd, rd_wen appear with out_valid=1 the cycle after accept.
REQ-021 out_valid SHALL hold and out_* SHALL stay stable while out_valid and not out_ready.
REQ-022 out_valid SHALL clear after out_ready handshake unless a new accept occurs the same cycle.
REQ-023 On accept with in_rd_wen and in_rd!=0, busy[in_rd] SHALL set next cycle.
REQ-024 wb_valid with wb_addr!=0 SHALL clear busy[wb_addr] next cycle; wb_addr==0 SHALL be ignored.
REQ-025 Same-cycle set and clear of the same register SHALL leave it set (set wins).
REQ-026 flush SHALL clear all busy bits and out_valid next cycle; in_ready SHALL be 0 during flush; wb in the flush cycle SHALL be ignored.
REQ-027 busy_cnt SHALL equal the population count of busy registered state.

Reset
REQ-028 While rst is high: all busy bits 0, out_valid 0, out_rs1_data/out_rs2_data 0, out_rd 0, out_rd_wen 0, busy_cnt 0.
REQ-029 Reset asserted mid-operation SHALL drop any pending output immediately; no handshake completes while rst is high.

Structure
REQ-030 Shared package SHALL define the AW width constant and the reg-address and operand data typedefs, reused by the register file and this block.
REQ-031 Scoreboard (busy vector, set/clear/flush, popcount) SHALL be a sub-module named reg_scoreboard; the stage register and bypass mux SHALL live in operand_fetch.

Verification
REQ-032 Reset: after rst release, busy_cnt=0, out_valid=0, in_ready=1 with out_ready=1.
REQ-033 Issue rd=5 wen=1, then rs1=5 next cycle without wb -> in_ready=0; wb_valid with wb_addr=5, wb_data=0xDEAD -> accepted that cycle, out_rs1_data=0xDEAD next cycle, busy_cnt back to 0.
REQ-034 Issue rs1=0, rs2=0 with rf_rdata nonzero -> both operands 0; rd=0 wen=1 -> busy_cnt stays 0.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 -> back-to-back accepts at 1 per cycle.
REQ-036 busy[7] set, new issue rd=7 with wb_addr=7 same cycle -> accepted, busy[7] remains 1, busy_cnt unchanged.
REQ-037 Three registers busy, flush=1 one cycle -> busy_cnt=0, out_valid=0 next cycle; an rs1=3 issue is then accepted without stall.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_pkg
// Description : Shared register-address / operand types for the register
//               file and operand fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

    localparam int REG_NUM_DEF    = 32;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int AW             = $clog2(REG_NUM_DEF);

    typedef logic [AW-1:0]             reg_addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] operand_t;

endpackage : operand_fetch_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register busy bits with set/clear/flush and popcount.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    localparam int RAW    = $clog2(REG_NUM),
    localparam int CW     = RAW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_valid_i,
    input  logic [RAW-1:0]     set_addr_i,
    input  logic               clr_valid_i,
    input  logic [RAW-1:0]     clr_addr_i,
    input  logic               flush_i,
    output logic [REG_NUM-1:0] busy_o,
    output logic [CW-1:0]      busy_cnt_o
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [CW-1:0]      cnt_w;

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_valid_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        cnt_w = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            cnt_w = cnt_w + CW'(busy_q[i]);
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_w;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Issue stage: hazard check, writeback bypass, 1-cycle stage reg.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int REG_NUM    = REG_NUM_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int RAW       = $clog2(REG_NUM),
    localparam int DW        = DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RAW-1:0]      in_rs1,
    input  logic [RAW-1:0]      in_rs2,
    input  logic [RAW-1:0]      in_rd,
    input  logic                in_rd_wen,
    output logic [1:0][RAW-1:0] rf_raddr,
    input  logic [1:0][DW-1:0]  rf_rdata,
    input  logic                wb_valid,
    input  logic [RAW-1:0]      wb_addr,
    input  logic [DW-1:0]       wb_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_rs1_data,
    output logic [DW-1:0]       out_rs2_data,
    output logic [RAW-1:0]      out_rd,
    output logic                out_rd_wen,
    output logic [RAW:0]        busy_cnt
);

    logic [REG_NUM-1:0]   busy_w;
    logic [1:0][RAW-1:0]  rs_w;
    logic [1:0][DW-1:0]   op_w;
    logic                 src_haz_w;
    logic                 waw_haz_w;
    logic                 accept_w;
    logic                 sb_set_w;
    logic                 sb_clr_w;

    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [DW-1:0]        rs1_data_q;
    logic [DW-1:0]        rs2_data_q;
    logic [RAW-1:0]       rd_q;
    logic                 rd_wen_q;

    assign rs_w[0]  = in_rs1;
    assign rs_w[1]  = in_rs2;
    assign rf_raddr = rs_w;

    // A writeback to a busy source resolves the hazard via the bypass path.
    always_comb begin
        src_haz_w = 1'b0;
        op_w      = '0;
        for (int n = 0; n < 2; n++) begin
            if (rs_w[n] != '0) begin
                if (wb_valid && (wb_addr == rs_w[n])) begin
                    op_w[n] = wb_data;
                end else begin
                    op_w[n] = rf_rdata[n];
                    if (busy_w[rs_w[n]]) begin
                        src_haz_w = 1'b1;
                    end
                end
            end
        end
    end

    assign waw_haz_w = in_rd_wen && (in_rd != '0) && busy_w[in_rd]
                       && !(wb_valid && (wb_addr == in_rd));

    assign in_ready  = !rst && !flush && !src_haz_w && !waw_haz_w
                       && (!out_valid_q || out_ready);
    assign accept_w  = in_valid && in_ready;

    assign sb_set_w  = accept_w && in_rd_wen && (in_rd != '0);
    assign sb_clr_w  = wb_valid && (wb_addr != '0);

    reg_scoreboard #(
        .REG_NUM (REG_NUM)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_valid_i (sb_set_w),
        .set_addr_i  (in_rd),
        .clr_valid_i (sb_clr_w),
        .clr_addr_i  (wb_addr),
        .flush_i     (flush),
        .busy_o      (busy_w),
        .busy_cnt_o  (busy_cnt)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_w) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rd_q        <= '0;
            rd_wen_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept_w) begin
                rs1_data_q <= op_w[0];
                rs2_data_q <= op_w[1];
                rd_q       <= in_rd;
                rd_wen_q   <= in_rd_wen;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = rs1_data_q;
    assign out_rs2_data = rs2_data_q;
    assign out_rd       = rd_q;
    assign out_rd_wen   = rd_wen_q;

endmodule : operand_fetch
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed + randomized self-checking bench for operand_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int RN = 32;
    localparam int DW = 64;
    localparam int AW_T = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [AW_T-1:0]      in_rs1, in_rs2, in_rd;
    logic                 in_rd_wen;
    logic [1:0][AW_T-1:0] rf_raddr;
    logic [1:0][DW-1:0]   rf_rdata;
    logic                 wb_valid;
    logic [AW_T-1:0]      wb_addr;
    logic [DW-1:0]        wb_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_rs1_data, out_rs2_data;
    logic [AW_T-1:0]      out_rd;
    logic                 out_rd_wen;
    logic [AW_T:0]        busy_cnt;

    operand_fetch #(.REG_NUM(RN), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: register file contents, busy set, pending output.
    operand_t   rf_m [RN];
    bit         busy_m [RN];
    bit         exp_valid;
    operand_t   exp_op1, exp_op2;
    reg_addr_t  exp_rd;
    bit         exp_wen;

    int n_chk = 0;
    int n_err = 0;
    bit last_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pop_m();
        int c = 0;
        for (int i = 0; i < RN; i++) c += int'(busy_m[i]);
        return c;
    endfunction

    function automatic operand_t opnd(input int rs, input bit wbv, input int wba, input operand_t wbd);
        if (rs == 0) return '0;
        if (wbv && wba == rs) return wbd;
        return rf_m[rs];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RN; i++) busy_m[i] = 1'b0;
        exp_valid = 1'b0;
        exp_op1 = '0; exp_op2 = '0; exp_rd = '0; exp_wen = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, exp_valid);
        chk("busy_cnt", busy_cnt, pop_m());
        if (exp_valid) begin
            chk("out_rs1_data", out_rs1_data, exp_op1);
            chk("out_rs2_data", out_rs2_data, exp_op2);
            chk("out_rd", out_rd, exp_rd);
            chk("out_rd_wen", out_rd_wen, exp_wen);
        end
    endtask

    // One clock of stimulus: drive, check combinational outputs, advance model,
    // cross the edge, then check registered outputs.
    task automatic step(input bit v, input int r1, input int r2, input int rd, input bit wen,
                        input bit wbv, input int wba, input operand_t wbd,
                        input bit fl, input bit ordy);
        bit haz, erdy, acc;
        logic [2*AW_T-1:0] exp_ra;
        in_valid  = v;
        in_rs1    = AW_T'(r1);
        in_rs2    = AW_T'(r2);
        in_rd     = AW_T'(rd);
        in_rd_wen = wen;
        rf_rdata[0] = rf_m[r1];
        rf_rdata[1] = rf_m[r2];
        wb_valid  = wbv;
        wb_addr   = AW_T'(wba);
        wb_data   = wbd;
        flush     = fl;
        out_ready = ordy;
        #1;
        haz = (r1 != 0 && busy_m[r1] && !(wbv && wba == r1))
           || (r2 != 0 && busy_m[r2] && !(wbv && wba == r2))
           || (wen && rd != 0 && busy_m[rd] && !(wbv && wba == rd));
        erdy = !fl && !haz && (!exp_valid || ordy);
        last_rdy = in_ready;
        chk("in_ready", in_ready, erdy);
        exp_ra = {AW_T'(r2), AW_T'(r1)};
        chk("rf_raddr", {rf_raddr[1], rf_raddr[0]}, exp_ra);
        acc = v && erdy;
        if (fl) begin
            for (int i = 0; i < RN; i++) busy_m[i] = 1'b0;
            exp_valid = 1'b0;
        end else begin
            if (wbv && wba != 0) busy_m[wba] = 1'b0;
            if (acc && wen && rd != 0) busy_m[rd] = 1'b1;
            if (acc) begin
                exp_valid = 1'b1;
                exp_op1 = opnd(r1, wbv, wba, wbd);
                exp_op2 = opnd(r2, wbv, wba, wbd);
                exp_rd  = AW_T'(rd);
                exp_wen = wen;
            end else if (ordy) begin
                exp_valid = 1'b0;
            end
        end
        if (wbv) rf_m[wba] = wbd;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wen = 0;
        rf_rdata = '0; wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0;
        out_ready = 1'b1;
        for (int i = 0; i < RN; i++) rf_m[i] = {$urandom, $urandom};
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_rs1_data", out_rs1_data, 64'h0);
        chk("rst_out_rd_wen", out_rd_wen, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_busy_cnt", busy_cnt, 0);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // RAW stall on r5 resolved by same-cycle writeback
        step(1, 0, 0, 5, 1, 0, 0, '0, 0, 1);
        chk("raw_busy_set", busy_cnt, 1);
        step(1, 5, 0, 9, 0, 0, 0, '0, 0, 1);
        chk("raw_stall", last_rdy, 1'b0);
        step(1, 5, 0, 9, 0, 1, 5, 64'hDEAD, 0, 1);
        chk("raw_bypass_accept", last_rdy, 1'b1);
        chk("raw_bypass_data", out_rs1_data, 64'hDEAD);
        chk("raw_busy_clear", busy_cnt, 0);

        // x0 sources read as zero; rd=0 never marks busy
        rf_m[0] = 64'hBAD0_BAD0_BAD0_BAD0;
        step(1, 0, 0, 0, 1, 0, 0, '0, 0, 1);
        chk("x0_rs1", out_rs1_data, 64'h0);
        chk("x0_rs2", out_rs2_data, 64'h0);
        chk("x0_busy_cnt", busy_cnt, 0);

        // Backpressure holds outputs; then 1-per-cycle throughput
        rf_m[1] = 64'h1111; rf_m[2] = 64'h2222;
        step(1, 1, 2, 3, 0, 0, 0, '0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 4, 4, 6, 0, 0, 0, '0, 0, 0);
            chk("bp_stall", last_rdy, 1'b0);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_rs1", out_rs1_data, 64'h1111);
            chk("bp_hold_rs2", out_rs2_data, 64'h2222);
        end
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 1, 0, 0, 0, 0, '0, 0, 1);
            chk("b2b_accept", last_rdy, 1'b1);
            chk("b2b_valid", out_valid, 1'b1);
        end

        // WAW with same-cycle writeback: set wins
        step(0, 0, 0, 0, 0, 0, 0, '0, 1, 1);
        step(1, 0, 0, 7, 1, 0, 0, '0, 0, 1);
        chk("waw_busy_before", busy_cnt, 1);
        step(1, 0, 0, 7, 1, 1, 7, 64'h77, 0, 1);
        chk("waw_accept", last_rdy, 1'b1);
        chk("waw_busy_after", busy_cnt, 1);
        step(1, 7, 0, 0, 0, 0, 0, '0, 0, 1);
        chk("waw_still_busy", last_rdy, 1'b0);

        // Flush wipes three busy registers
        step(0, 0, 0, 0, 0, 0, 0, '0, 1, 1);
        step(1, 0, 0, 1, 1, 0, 0, '0, 0, 1);
        step(1, 0, 0, 2, 1, 0, 0, '0, 0, 1);
        step(1, 0, 0, 3, 1, 0, 0, '0, 0, 1);
        chk("flush_pre_cnt", busy_cnt, 3);
        step(1, 0, 0, 0, 0, 0, 0, '0, 1, 1);
        chk("flush_ready_low", last_rdy, 1'b0);
        chk("flush_cnt", busy_cnt, 0);
        chk("flush_valid", out_valid, 1'b0);
        step(1, 3, 0, 0, 0, 0, 0, '0, 0, 1);
        chk("post_flush_accept", last_rdy, 1'b1);

        // Randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            if (i == 900) begin
                in_valid = 1'b0;
                rst = 1'b1;
                #1;
                chk("midrst_out_valid", out_valid, 1'b0);
                chk("midrst_busy_cnt", busy_cnt, 0);
                chk("midrst_in_ready", in_ready, 1'b0);
                chk("midrst_out_rs1", out_rs1_data, 64'h0);
                model_clear();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) < 2, int'($urandom_range(0, 7)),
                 {$urandom, $urandom},
                 $urandom_range(0, 40) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_operand_fetch
`default_nettype wire
